// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared state types and default command bytes for the BLE command path
package segway_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

    localparam logic [7:0] GO_CMD_DEFAULT   = 8'h67;
    localparam logic [7:0] STOP_CMD_DEFAULT = 8'h73;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with two-flop synchronizer and mid-bit sampling
import segway_pkg::*;

module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    localparam logic [15:0] BAUD_FULL = 16'(BAUD_DIV);
    localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

    rx_state_t   state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        expired;

    // A load of N expires N cycles later; the counter parks instead of wrapping.
    assign expired = (baud_cnt <= 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            rx_rdy  <= 1'b0;
            frm_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state    <= START;
                        baud_cnt <= BAUD_HALF;
                    end
                end
                START: begin
                    if (expired) begin
                        if (!rx_sync) begin
                            state    <= DATA;
                            baud_cnt <= BAUD_FULL;
                            bit_cnt  <= '0;
                        end else begin
                            state    <= IDLE;
                            baud_cnt <= '0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (expired) begin
                        shift    <= {rx_sync, shift[7:1]};
                        baud_cnt <= BAUD_FULL;
                        if (bit_cnt == 4'd7) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (expired) begin
                        state    <= IDLE;
                        baud_cnt <= '0;
                        if (rx_sync) begin
                            rx_data <= shift;
                            rx_rdy  <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ble_cmd_rcv.sv
// rtl/ble_cmd_rcv.sv - BLE command receiver gating power-up on go/stop bytes and rider presence
import segway_pkg::*;

module ble_cmd_rcv #(
    parameter int         BAUD_DIV = 2604,
    parameter logic [7:0] GO_CMD   = GO_CMD_DEFAULT,
    parameter logic [7:0] STOP_CMD = STOP_CMD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rider_off,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       pwr_up
);

    auth_state_t auth_state;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .frm_err (frm_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            auth_state <= OFF;
            pwr_up     <= 1'b0;
        end else begin
            case (auth_state)
                OFF: begin
                    if (rx_rdy && rx_data == GO_CMD) begin
                        auth_state <= PWR1;
                        pwr_up     <= 1'b1;
                    end
                end
                PWR1: begin
                    if (rx_rdy && rx_data == STOP_CMD) begin
                        if (rider_off) begin
                            auth_state <= OFF;
                            pwr_up     <= 1'b0;
                        end else begin
                            auth_state <= PWR2;
                        end
                    end
                end
                PWR2: begin
                    // A dismount wins over a simultaneous go byte so power never stays on riderless.
                    if (rider_off) begin
                        auth_state <= OFF;
                        pwr_up     <= 1'b0;
                    end else if (rx_rdy && rx_data == GO_CMD) begin
                        auth_state <= PWR1;
                    end
                end
                default: begin
                    auth_state <= OFF;
                    pwr_up     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_cmd_rcv.sv
// tb/tb_ble_cmd_rcv.sv - directed self-checking bench for ble_cmd_rcv
module tb_ble_cmd_rcv;

    localparam int BAUD = 64;
    localparam int FRAME_LAT = 3 + BAUD / 2 + 9 * BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       pwr_up;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rdy_cyc = 0;
    int rdy_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [7:0] rdy_log [0:63];
    logic rdy_pwr_at = 1'b0;
    logic rdy_pwr_after = 1'b0;
    logic rdy_pend = 1'b0;
    int base_rdy;
    int base_err;

    ble_cmd_rcv #(.BAUD_DIV(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rider_off (rider_off),
        .rx_data   (rx_data),
        .rx_rdy    (rx_rdy),
        .frm_err   (frm_err),
        .pwr_up    (pwr_up)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rdy_pend) begin
            rdy_pwr_after = pwr_up;
            rdy_pend = 1'b0;
        end
        if (rx_rdy) begin
            rdy_log[rdy_cnt] = rx_data;
            rdy_cyc = cyc;
            rdy_pwr_at = pwr_up;
            rdy_cnt++;
            rdy_pend = 1'b1;
        end
        if (frm_err) err_cnt++;
        if (rx_rdy && frm_err) both_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v);
        RX = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    // Assumes the caller is at posedge+1; ends at posedge+1 so frames can abut.
    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        start_cyc = cyc;
        hold(1'b0);
        for (int i = 0; i < 8; i++) hold(d[i]);
        hold(stop_bit);
        RX = 1'b1;
    endtask

    initial begin
        settle(5);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_rdy", 32'(rx_rdy), 32'h0);
        check("reset_frm_err", 32'(frm_err), 32'h0);
        check("reset_pwr_up", 32'(pwr_up), 32'h0);
        rst = 1'b0;
        settle(5);

        send_byte(8'h67, 1'b1);
        check("go_rdy_count", 32'(rdy_cnt), 32'd1);
        check("go_data", 32'(rdy_log[0]), 32'h67);
        check("go_latency", 32'(rdy_cyc - start_cyc), 32'(FRAME_LAT));
        check("go_pwr_at_rdy", 32'(rdy_pwr_at), 32'h0);
        check("go_pwr_after", 32'(rdy_pwr_after), 32'h1);

        send_byte(8'h73, 1'b1);
        check("stop_rider_on_data", 32'(rdy_log[1]), 32'h73);
        check("stop_rider_on_pwr", 32'(pwr_up), 32'h1);
        rider_off = 1'b1;
        check("dismount_same_cycle", 32'(pwr_up), 32'h1);
        settle(1);
        check("dismount_next_cycle", 32'(pwr_up), 32'h0);
        rider_off = 1'b0;
        settle(3);

        send_byte(8'h67, 1'b1);
        check("go2_pwr", 32'(pwr_up), 32'h1);
        rider_off = 1'b1;
        send_byte(8'h73, 1'b1);
        check("stop_rider_off_at_rdy", 32'(rdy_pwr_at), 32'h1);
        check("stop_rider_off_after", 32'(rdy_pwr_after), 32'h0);
        rider_off = 1'b0;
        settle(3);

        send_byte(8'h67, 1'b1);
        base_rdy = rdy_cnt;
        base_err = err_cnt;
        send_byte(8'hA5, 1'b0);
        settle(BAUD);
        check("bad_stop_err_count", 32'(err_cnt - base_err), 32'd1);
        check("bad_stop_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
        check("bad_stop_data_kept", 32'(rx_data), 32'h67);
        check("bad_stop_pwr", 32'(pwr_up), 32'h1);
        send_byte(8'h73, 1'b0);
        settle(BAUD);
        check("bad_stop_cmd_ignored", 32'(pwr_up), 32'h1);
        check("bad_stop_err_count2", 32'(err_cnt - base_err), 32'd2);

        base_rdy = rdy_cnt;
        send_byte(8'h67, 1'b1);
        send_byte(8'h55, 1'b1);
        settle(4);
        check("b2b_rdy_count", 32'(rdy_cnt - base_rdy), 32'd2);
        check("b2b_first", 32'(rdy_log[base_rdy]), 32'h67);
        check("b2b_second", 32'(rdy_log[base_rdy + 1]), 32'h55);
        check("b2b_rx_data", 32'(rx_data), 32'h55);

        base_rdy = rdy_cnt;
        base_err = err_cnt;
        RX = 1'b0;
        settle(BAUD / 2 - 6);
        RX = 1'b1;
        settle(2 * BAUD);
        check("glitch_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
        check("glitch_no_err", 32'(err_cnt - base_err), 32'd0);

        hold(1'b0);
        for (int i = 0; i < 4; i++) hold(1'(8'h67 >> i));
        RX = 1'b0;
        settle(BAUD / 2);
        rst = 1'b1;
        RX = 1'b1;
        settle(2);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_rx_rdy", 32'(rx_rdy), 32'h0);
        check("midrst_frm_err", 32'(frm_err), 32'h0);
        check("midrst_pwr_up", 32'(pwr_up), 32'h0);
        rst = 1'b0;
        settle(12 * BAUD);
        check("midrst_no_rdy", 32'(rdy_cnt - base_rdy), 32'd0);
        check("midrst_no_err", 32'(err_cnt - base_err), 32'd0);
        send_byte(8'h67, 1'b1);
        settle(2);
        check("post_rst_rdy", 32'(rdy_cnt - base_rdy), 32'd1);
        check("post_rst_data", 32'(rx_data), 32'h67);
        check("post_rst_pwr", 32'(pwr_up), 32'h1);

        check("never_both_pulses", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
